oc8051_ecc_enc_pipe: RTL and testbench
======================================

Name: oc8051_ecc_enc_pipe

Overview:
Pipelined, multi-lane extended-Hamming (SECDED) encoder with valid/ready flow control, a selectable pipeline depth, and a one-shot error-injection facility for exercising downstream decoders. It sits between a data producer (memory write path, bus bridge) and ECC-protected storage, encoding LANES independent K-bit words per transfer. It adds registered timing, backpressure, fault injection and a transfer counter.

Parameters:
K, 8, information bits per lane (>=1)
LANES, 1, independent encoder lanes per transfer (>=1)
STAGES, 1, pipeline depth, 1 or 2; any other value is an elaboration error
P0_LSB, 1, 1: extended parity at codeword LSB; 0: at MSB
M, derived, smallest M with 2^M >= M+K+1 (K=8 -> 4)
N, derived, M+K; each lane codeword is N+1 bits (K=8 -> 13)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
valid_i  in  1  input word valid
ready_o  out  1  block can accept input this cycle
d_i  in  LANES*K  data, lane L at [L*K +: K]
valid_o  out  1  encoded word valid
ready_i  in  1  downstream accepts output
q_o  out  LANES*(N+1)  codewords, lane L at [L*(N+1) +: N+1]
inj_arm_i  in  1  pulse: arm one-shot injection
inj_mask_i  in  LANES*(N+1)  XOR mask, sampled when inj_arm_i=1
inj_flag_o  out  1  current output word carries injected mask
xfer_cnt_o  out  16  count of output transfers (valid_o & ready_i)

Behaviour:
- Reset (async assert, sync deassert to clk): all stage valids 0, valid_o=0, q_o=0, inj_flag_o=0, armed flag 0, stored mask 0, xfer_cnt_o=0. Reset mid-transfer discards in-flight words; no partial output.
- Encoding per lane: codeword positions 1..N; data bits d[0..K-1] fill non-power-of-2 positions in ascending order; parity p_i (i=1..M) at position 2^(i-1) = XOR of all data positions whose index has bit i-1 set; p0 = XOR of positions 1..N. Lane output = P0_LSB ? {cw[N:1],p0} : {p0,cw[N:1]}.
- Handshake: input accepted when valid_i & ready_o; output transferred when valid_o & ready_i. valid_o never drops and q_o/inj_flag_o never change while valid_o=1 & ready_i=0.
- Pipeline: each stage has a valid bit; stage loads when it is empty or its successor is loading/transferring. ready_o = !stage1_valid | stage1_advances (combinational from ready_i). Full throughput: one word per cycle with ready_i held 1.
- Latency: STAGES=1 -> word accepted at cycle t is on q_o at t+1. STAGES=2 -> t+2; stage 1 registers data-placed codeword plus p1..pM, stage 2 registers p0 and final assembly.
- Injection: inj_arm_i=1 stores inj_mask_i and sets armed (later arm pulses while armed overwrite the mask). The next accepted input word (including one accepted in the same cycle as the arm) is tagged; armed clears on that acceptance. Tagged word's q_o = encoded ^ mask, inj_flag_o=1 with it. Mask 0 with arm still tags (flag=1, data unchanged).
- xfer_cnt_o increments on each output transfer, wraps 0xFFFF -> 0x0000.
- valid_i & !ready_o: input ignored, producer must hold.

Decomposition:
- Package oc8051_ecc_pkg: functions calc_m(k), place_dbits, calc_parity, place_parity (shared with decoder); typedef for 16-bit counter.
- Sub-module oc8051_ecc_enc_lane: one-lane combinational placement + parity split at a STAGES-selectable register boundary; generate LANES instances. Handshake, injection and counter stay in the top.

Test Plan:
- K=8,LANES=1,STAGES=1,P0_LSB=1: d_i=0x00 -> q_o=0x0000; d_i=0x01 -> q_o=0x000F; d_i=0xFF -> q_o=0x1EEE, each 1 cycle after accept.
- P0_LSB=0, d_i=0x01 -> q_o=0x1007; d_i=0xFF -> q_o=0x0F77.
- STAGES=2, 100 random back-to-back words, ready_i=1 -> outputs match reference model, latency 2, no bubbles; ready_i random 50% -> no loss/duplication, q_o stable while stalled, xfer_cnt_o=100.
- Arm with mask=0x0001 concurrent with accepting d_i=0xFF -> that word q_o=0x1EEF, inj_flag_o=1; next word untagged, flag 0.
- LANES=2, d_i=0xFF01 -> q_o={0x1EEE,0x000F}; mask only on lane 1 bit 3 flips only lane 1.
- Assert rst with 2 words in flight and armed -> valid_o=0 immediately, xfer_cnt_o=0; post-reset word untagged.

Source files
------------

// File: rtl/oc8051_ecc_pkg.sv
// Purpose: shared extended-Hamming (SECDED) helpers for the oc8051 ECC encoder/decoder.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Codeword vectors (cw_t) are indexed by Hamming position: bit 1 is position 1, and so on.
// Bit 0 is left free so that index and position never need translating.
package oc8051_ecc_pkg;

  localparam int MAX_M = 6;
  localparam int MAX_N = 63;

  typedef logic [15:0]      xfer_cnt_t;
  typedef logic [MAX_N:0]   cw_t;
  typedef logic [MAX_M-1:0] par_t;   // par[i] holds p_(i+1), stored at position 2^i

  // Smallest m with 2^m >= m + k + 1.
  function automatic int calc_m(input int k);
    int m;
    m = 0;
    for (int i = 1; i <= MAX_M; i++) begin
      if (m == 0 && (1 << i) >= i + k + 1) m = i;
    end
    return m;
  endfunction

  function automatic bit is_pow2(input int pos);
    return (pos & (pos - 1)) == 0;
  endfunction

  // Data bits fill the non-power-of-2 positions 1..n in ascending order.
  function automatic cw_t place_dbits(input logic [MAX_N-1:0] d, input int k, input int n);
    cw_t cw;
    int  di;
    cw = '0;
    di = 0;
    for (int pos = 1; pos <= MAX_N; pos++) begin
      if (pos <= n && !is_pow2(pos) && di < k) begin
        cw[pos] = d[di];
        di++;
      end
    end
    return cw;
  endfunction

  // p_(i+1) covers every data position whose index has bit i set.
  function automatic par_t calc_parity(input cw_t cw, input int m, input int n);
    par_t par;
    par = '0;
    for (int i = 0; i < MAX_M; i++) begin
      for (int pos = 1; pos <= MAX_N; pos++) begin
        if (i < m && pos <= n && !is_pow2(pos) && ((pos >> i) & 1) == 1)
          par[i] = par[i] ^ cw[pos];
      end
    end
    return par;
  endfunction

  function automatic cw_t place_parity(input cw_t cw, input par_t par, input int m);
    cw_t r;
    r = cw;
    for (int i = 0; i < MAX_M; i++) begin
      if (i < m) r[1 << i] = par[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/oc8051_ecc_enc_lane.sv
// Purpose: one lane of the SECDED encoder: data placement, Hamming parity and overall parity p0.
// Latency: STAGES register stages; en[s] loads stage s (driven by the top's pipeline control).
// Backpressure: none locally; every register holds its value while its enable is low.
// Ports: clk/rst, en (per-stage load), d (K data bits), q (registered N+1 bit codeword).
module oc8051_ecc_enc_lane
  import oc8051_ecc_pkg::*;
#(
  parameter  int K      = 8,
  parameter  int STAGES = 1,
  parameter  int P0_LSB = 1,
  localparam int M      = calc_m(K),
  localparam int N      = M + K
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] en,
  input  logic [K-1:0]      d,
  output logic [N:0]        q
);

  logic [MAX_N-1:0] d_ext;
  logic [N:1]       cw_full;   // positions 1..N with data and p1..pM in place

  assign d_ext = {{(MAX_N-K){1'b0}}, d};

  always_comb begin
    cw_t t;
    t       = place_dbits(d_ext, K, N);
    t       = place_parity(t, calc_parity(t, M, N), M);
    cw_full = t[N:1];
  end

  // p0 covers positions 1..N including the Hamming parity bits.
  function automatic logic [N:0] assemble(input logic [N:1] cw);
    logic p0;
    p0 = ^cw;
    return (P0_LSB != 0) ? {cw, p0} : {p0, cw};
  endfunction

  if (STAGES == 1) begin : g_one
    always_ff @(posedge clk or posedge rst) begin
      if (rst)        q <= '0;
      else if (en[0]) q <= assemble(cw_full);
    end
  end else begin : g_two
    // Stage boundary after the Hamming parity; p0 and final ordering happen in stage 2.
    logic [N:1] s1;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)        s1 <= '0;
      else if (en[0]) s1 <= cw_full;
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst)               q <= '0;
      else if (en[STAGES-1]) q <= assemble(s1);
    end
  end

endmodule

// File: rtl/oc8051_ecc_enc_pipe.sv
// Purpose: LANES-wide pipelined SECDED encoder with one-shot error injection and transfer counter.
// Latency: STAGES cycles (1 or 2) from input accept to valid_o; one word per cycle sustained.
// Backpressure: valid/ready; ready_o = stage 1 empty or advancing (combinational from ready_i).
// Ports: valid_i/ready_o/d_i input side; valid_o/ready_i/q_o output side;
//        inj_arm_i/inj_mask_i arm an XOR mask for the next accepted word, inj_flag_o marks it;
//        xfer_cnt_o counts output transfers (wraps at 16 bits).
module oc8051_ecc_enc_pipe
  import oc8051_ecc_pkg::*;
#(
  parameter  int K      = 8,
  parameter  int LANES  = 1,
  parameter  int STAGES = 1,
  parameter  int P0_LSB = 1,
  localparam int M      = calc_m(K),
  localparam int N      = M + K,
  localparam int W      = LANES * (N + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [LANES*K-1:0] d_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [W-1:0]       q_o,
  input  logic               inj_arm_i,
  input  logic [W-1:0]       inj_mask_i,
  output logic               inj_flag_o,
  output logic [15:0]        xfer_cnt_o
);

  if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
    $error("oc8051_ecc_enc_pipe: STAGES must be 1 or 2");
  end

  logic [STAGES-1:0] stg_vld;
  logic [STAGES-1:0] stg_flag;
  logic [W-1:0]      stg_mask [STAGES];
  logic [STAGES-1:0] adv;       // stage may load this cycle
  logic [STAGES-1:0] en;        // stage actually loads a word this cycle
  logic              armed;
  logic [W-1:0]      arm_mask;
  logic              accept;
  logic              out_xfer;
  logic              tag_now;
  logic [W-1:0]      mask_now;
  logic [W-1:0]      lane_q;
  xfer_cnt_t         xfer_cnt;

  // A stage can take a word when it is empty or its own word moves on this cycle.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = !stg_vld[STAGES-1] || ready_i;
    for (int s = STAGES - 2; s >= 0; s--) begin
      adv[s] = !stg_vld[s] || adv[s+1];
    end
  end

  assign ready_o  = adv[0];
  assign accept   = valid_i && adv[0];
  assign valid_o  = stg_vld[STAGES-1];
  assign out_xfer = valid_o && ready_i;

  always_comb begin
    en    = '0;
    en[0] = accept;
    for (int s = 1; s < STAGES; s++) begin
      en[s] = adv[s] && stg_vld[s-1];
    end
  end

  // An arm pulse in the same cycle as an accept tags that very word.
  assign tag_now  = inj_arm_i || armed;
  assign mask_now = inj_arm_i ? inj_mask_i : arm_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed    <= 1'b0;
      arm_mask <= '0;
    end else begin
      if (inj_arm_i) arm_mask <= inj_mask_i;
      if (accept)         armed <= 1'b0;
      else if (inj_arm_i) armed <= 1'b1;
    end
  end

  // The mask travels with its word so a later re-arm cannot alter a word already in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_vld  <= '0;
      stg_flag <= '0;
      for (int s = 0; s < STAGES; s++) stg_mask[s] <= '0;
    end else begin
      if (adv[0]) stg_vld[0] <= valid_i;
      if (en[0]) begin
        stg_flag[0] <= tag_now;
        stg_mask[0] <= tag_now ? mask_now : '0;
      end
      for (int s = 1; s < STAGES; s++) begin
        if (adv[s]) stg_vld[s] <= stg_vld[s-1];
        if (en[s]) begin
          stg_flag[s] <= stg_flag[s-1];
          stg_mask[s] <= stg_mask[s-1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           xfer_cnt <= '0;
    else if (out_xfer) xfer_cnt <= xfer_cnt + 16'd1;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    oc8051_ecc_enc_lane #(
      .K      (K),
      .STAGES (STAGES),
      .P0_LSB (P0_LSB)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   (d_i[l*K +: K]),
      .q   (lane_q[l*(N+1) +: N+1])
    );
  end

  // Both terms come straight from registers, so q_o is stable while stalled.
  assign q_o        = lane_q ^ stg_mask[STAGES-1];
  assign inj_flag_o = valid_o && stg_flag[STAGES-1];
  assign xfer_cnt_o = xfer_cnt;

endmodule

// File: tb/tb_oc8051_ecc_enc_pipe.sv
// Bench for oc8051_ecc_enc_pipe: two instances (K=8, LANES=2), one STAGES=2/P0_LSB=1,
// one STAGES=1/P0_LSB=0, driven with directed and random words; a scoreboard queue per
// instance is filled at accept time and drained by an independent output monitor.
module tb_oc8051_ecc_enc_pipe;

  typedef struct {
    logic [25:0] q;
    logic        flag;
    int          cyc;
    bit          lat;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        vin   [2];
  logic        rdy_o [2];
  logic [15:0] din   [2];
  logic        vo    [2];
  logic        rdy_i [2];
  logic [25:0] qo    [2];
  logic        arm   [2];
  logic [25:0] mask  [2];
  logic        flg   [2];
  logic [15:0] xfer  [2];

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          mode      [2];
  int          sent      [2];
  bit          model_armed [2];
  logic [25:0] model_mask  [2];
  bit          prev_stall  [2];
  logic [25:0] prev_q      [2];
  logic        prev_f      [2];
  exp_t        sb0[$];
  exp_t        sb1[$];

  oc8051_ecc_enc_pipe #(.K(8), .LANES(2), .STAGES(2), .P0_LSB(1)) dut_a (
    .clk(clk), .rst(rst), .valid_i(vin[0]), .ready_o(rdy_o[0]), .d_i(din[0]),
    .valid_o(vo[0]), .ready_i(rdy_i[0]), .q_o(qo[0]), .inj_arm_i(arm[0]),
    .inj_mask_i(mask[0]), .inj_flag_o(flg[0]), .xfer_cnt_o(xfer[0])
  );

  oc8051_ecc_enc_pipe #(.K(8), .LANES(2), .STAGES(1), .P0_LSB(0)) dut_b (
    .clk(clk), .rst(rst), .valid_i(vin[1]), .ready_o(rdy_o[1]), .d_i(din[1]),
    .valid_o(vo[1]), .ready_i(rdy_i[1]), .q_o(qo[1]), .inj_arm_i(arm[1]),
    .inj_mask_i(mask[1]), .inj_flag_o(flg[1]), .xfer_cnt_o(xfer[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int stg(input int u);
    return (u == 0) ? 2 : 1;
  endfunction

  function automatic bit p0lsb(input int u);
    return (u == 0);
  endfunction

  // Reference: the Hamming parity bits are the XOR of the indices of all set data positions.
  function automatic logic [12:0] enc_ref(input logic [7:0] d, input bit lsb);
    logic [12:0] cw;
    logic [3:0]  syn;
    logic        p0;
    int          di;
    cw  = '0;
    syn = '0;
    di  = 0;
    for (int pos = 1; pos <= 12; pos++) begin
      if (pos != 1 && pos != 2 && pos != 4 && pos != 8) begin
        cw[pos] = d[di];
        if (d[di]) syn = syn ^ 4'(pos);
        di++;
      end
    end
    for (int i = 0; i < 4; i++) cw[1 << i] = syn[i];
    p0 = ($countones(cw[12:1]) % 2) == 1;
    return lsb ? {cw[12:1], p0} : {p0, cw[12:1]};
  endfunction

  function automatic logic [25:0] enc2(input int u, input logic [15:0] d);
    return {enc_ref(d[15:8], p0lsb(u)), enc_ref(d[7:0], p0lsb(u))};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int sb_size(input int u);
    return (u == 0) ? sb0.size() : sb1.size();
  endfunction

  task automatic sb_push(input int u, input exp_t e);
    if (u == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  task automatic sb_pop(input int u, output exp_t e);
    if (u == 0) e = sb0.pop_front();
    else        e = sb1.pop_front();
  endtask

  // Presents one word (optionally with a concurrent arm) and holds it until accepted.
  task automatic send(input int u, input logic [15:0] data, input logic a,
                      input logic [25:0] m, input logic [25:0] exp_q, input logic exp_f);
    exp_t e;
    bit   done;
    done    = 0;
    vin[u]  = 1'b1;
    din[u]  = data;
    arm[u]  = a;
    mask[u] = m;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (rdy_o[u]) begin
        e.q    = exp_q;
        e.flag = exp_f;
        e.cyc  = cyc + stg(u);
        e.lat  = (mode[u] == 0);
        sb_push(u, e);
        sent[u]++;
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    arm[u] = 1'b0;
    if (!done) chk($sformatf("accept_timeout%0d", u), 32'd1, 32'd0);
    else       model_armed[u] = 0;
  endtask

  task automatic arm_only(input int u, input logic [25:0] m);
    vin[u]  = 1'b0;
    arm[u]  = 1'b1;
    mask[u] = m;
    @(posedge clk);
    #1;
    arm[u] = 1'b0;
    model_armed[u] = 1;
    model_mask[u]  = m;
  endtask

  task automatic idle(input int u);
    vin[u] = 1'b0;
    arm[u] = 1'b0;
  endtask

  task automatic rand_burst(input int u, input int cnt, input bit inj);
    logic [15:0] data;
    logic [25:0] m;
    logic        a;
    logic        tag;
    logic [25:0] mk;
    for (int i = 0; i < cnt; i++) begin
      data = 16'($urandom);
      a    = inj && ($urandom_range(0, 7) == 0);
      m    = 26'($urandom);
      tag  = a || model_armed[u];
      mk   = a ? m : model_mask[u];
      send(u, data, a, m, enc2(u, data) ^ (tag ? mk : 26'd0), tag);
    end
    idle(u);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && n < 1000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 1000) chk("drain_timeout", 32'd1, 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Ready pattern per instance: 0 = always ready, 1 = random 50%, 2 = stalled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
        case (mode[u])
          0:       rdy_i[u] = 1'b1;
          1:       rdy_i[u] = 1'($urandom_range(0, 1));
          default: rdy_i[u] = 1'b0;
        endcase
      end
    end
  end

  // Output monitor: pops expectations on each transfer, checks hold during stalls.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        if (rst) begin
          prev_stall[u] = 0;
        end else begin
          if (prev_stall[u]) begin
            chk($sformatf("stall_valid%0d", u), 32'(vo[u]), 32'd1);
            chk($sformatf("stall_q%0d", u), 32'(qo[u]), 32'(prev_q[u]));
            chk($sformatf("stall_flag%0d", u), 32'(flg[u]), 32'(prev_f[u]));
          end
          if (vo[u] && rdy_i[u]) begin
            if (sb_size(u) == 0) begin
              chk($sformatf("unexpected_out%0d", u), 32'd1, 32'd0);
            end else begin
              sb_pop(u, e);
              chk($sformatf("q%0d", u), 32'(qo[u]), 32'(e.q));
              chk($sformatf("flag%0d", u), 32'(flg[u]), 32'(e.flag));
              if (e.lat) chk($sformatf("latency%0d", u), 32'(cyc), 32'(e.cyc));
            end
          end
          prev_stall[u] = vo[u] && !rdy_i[u];
          prev_q[u]     = qo[u];
          prev_f[u]     = flg[u];
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      vin[u] = 1'b0; din[u] = '0; arm[u] = 1'b0; mask[u] = '0; rdy_i[u] = 1'b1;
      mode[u] = 0; sent[u] = 0; model_armed[u] = 0; model_mask[u] = '0; prev_stall[u] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("rst_valid%0d", u), 32'(vo[u]), 32'd0);
      chk($sformatf("rst_q%0d", u), 32'(qo[u]), 32'd0);
      chk($sformatf("rst_flag%0d", u), 32'(flg[u]), 32'd0);
      chk($sformatf("rst_xfer%0d", u), 32'(xfer[u]), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed encodings, P0 at MSB, single-stage.
    send(1, 16'h0000, 1'b0, 26'd0, 26'd0, 1'b0);
    send(1, 16'hFF01, 1'b0, 26'd0, {13'h0F77, 13'h1007}, 1'b0);
    idle(1);
    // Directed encodings, P0 at LSB, two-stage, plus injection cases.
    send(0, 16'h0000, 1'b0, 26'd0, 26'd0, 1'b0);
    send(0, 16'h0001, 1'b0, 26'd0, {13'h0000, 13'h000F}, 1'b0);
    send(0, 16'hFF01, 1'b0, 26'd0, {13'h1EEE, 13'h000F}, 1'b0);
    send(0, 16'h00FF, 1'b1, 26'h0000001, {13'h0000, 13'h1EEF}, 1'b1);
    send(0, 16'h00FF, 1'b0, 26'd0, {13'h0000, 13'h1EEE}, 1'b0);
    arm_only(0, 26'h0010000);
    send(0, 16'hFF01, 1'b0, 26'd0, {13'h1EE6, 13'h000F}, 1'b1);
    send(0, 16'h0001, 1'b1, 26'd0, {13'h0000, 13'h000F}, 1'b1);
    arm_only(0, 26'h3FFFFFF);
    arm_only(0, 26'h0000100);
    send(0, 16'h0000, 1'b0, 26'd0, 26'h0000100, 1'b1);
    send(0, 16'h0000, 1'b0, 26'd0, 26'd0, 1'b0);
    idle(0);
    drain();

    // Back-to-back random words with output always ready: exact latency, no bubbles.
    fork
      rand_burst(0, 100, 1'b0);
      rand_burst(1, 100, 1'b0);
    join
    drain();

    // Random backpressure with random injection.
    mode[0] = 1;
    mode[1] = 1;
    fork
      rand_burst(0, 100, 1'b1);
      rand_burst(1, 100, 1'b1);
    join
    mode[0] = 0;
    mode[1] = 0;
    drain();
    for (int u = 0; u < 2; u++)
      chk($sformatf("xfer_cnt%0d", u), 32'(xfer[u]), 32'(sent[u] & 16'hFFFF));

    // Reset with two words in flight and injection armed.
    mode[0] = 2;
    @(posedge clk);
    #2;
    send(0, 16'h1234, 1'b0, 26'd0, enc2(0, 16'h1234), 1'b0);
    send(0, 16'h5678, 1'b0, 26'd0, enc2(0, 16'h5678), 1'b0);
    arm_only(0, 26'h0000002);
    chk("inflight_valid", 32'(vo[0]), 32'd1);
    #2;
    rst = 1'b1;
    prev_stall[0] = 0;
    prev_stall[1] = 0;
    #1;
    chk("rst_mid_valid", 32'(vo[0]), 32'd0);
    chk("rst_mid_xfer", 32'(xfer[0]), 32'd0);
    chk("rst_mid_flag", 32'(flg[0]), 32'd0);
    sb0.delete();
    sb1.delete();
    for (int u = 0; u < 2; u++) begin
      sent[u] = 0;
      model_armed[u] = 0;
    end
    mode[0] = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(0, 16'h0001, 1'b0, 26'd0, {13'h0000, 13'h000F}, 1'b0);
    idle(0);
    drain();
    chk("post_rst_xfer", 32'(xfer[0]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
